// File: rtl/commit_queue_pkg.sv
// Shared definitions for the commit-trace queue: default sizing and the layout
// of one stored commit record.
package commit_queue_pkg;

    localparam int CQ_DEF_COMMIT_WIDTH = 2;
    localparam int CQ_DEF_DEPTH        = 16;
    localparam int CQ_DEF_DMEM_AW      = 10;

    // Fixed-width fields sit low; the data-memory address goes on top so
    // every offset below is independent of DMEM_AW.
    localparam int CQ_PC_LSB      = 0;
    localparam int CQ_INSTR_LSB   = 32;
    localparam int CQ_HALT_BIT    = 64;
    localparam int CQ_REG_WE_BIT  = 65;
    localparam int CQ_REG_WA_LSB  = 66;
    localparam int CQ_REG_WD_LSB  = 71;
    localparam int CQ_DMEM_WE_BIT = 103;
    localparam int CQ_DMEM_WD_LSB = 104;
    localparam int CQ_DMEM_WA_LSB = 136;
    localparam int CQ_FIXED_W     = 136;

    function automatic int cq_entry_w(input int dmem_aw);
        return CQ_FIXED_W + dmem_aw;
    endfunction

endpackage

// File: rtl/commit_queue_if.sv
// Commit-side and harness-side handshake bundle of the commit queue.
interface commit_queue_if
    import commit_queue_pkg::*;
#(
    parameter int COMMIT_WIDTH = CQ_DEF_COMMIT_WIDTH,
    parameter int DMEM_AW      = CQ_DEF_DMEM_AW
) ();

    logic [COMMIT_WIDTH-1:0]         in_valid;
    logic                            in_ready;
    logic [COMMIT_WIDTH*32-1:0]      in_pc;
    logic [COMMIT_WIDTH*32-1:0]      in_instr;
    logic [COMMIT_WIDTH-1:0]         in_halt;
    logic [COMMIT_WIDTH-1:0]         in_reg_we;
    logic [COMMIT_WIDTH*5-1:0]       in_reg_wa;
    logic [COMMIT_WIDTH*32-1:0]      in_reg_wd;
    logic [COMMIT_WIDTH-1:0]         in_dmem_we;
    logic [COMMIT_WIDTH*DMEM_AW-1:0] in_dmem_wa;
    logic [COMMIT_WIDTH*32-1:0]      in_dmem_wd;

    logic                            out_valid;
    logic                            out_ready;
    logic [31:0]                     out_pc;
    logic [31:0]                     out_instr;
    logic                            out_halt;
    logic                            out_reg_we;
    logic [4:0]                      out_reg_wa;
    logic [31:0]                     out_reg_wd;
    logic                            out_dmem_we;
    logic [DMEM_AW-1:0]              out_dmem_wa;
    logic [31:0]                     out_dmem_wd;

    modport master (
        output in_valid, in_pc, in_instr, in_halt, in_reg_we, in_reg_wa, in_reg_wd,
               in_dmem_we, in_dmem_wa, in_dmem_wd, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_halt, out_reg_we,
               out_reg_wa, out_reg_wd, out_dmem_we, out_dmem_wa, out_dmem_wd
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_halt, in_reg_we, in_reg_wa, in_reg_wd,
               in_dmem_we, in_dmem_wa, in_dmem_wd, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_halt, out_reg_we,
               out_reg_wa, out_reg_wd, out_dmem_we, out_dmem_wa, out_dmem_wd
    );

endinterface

// File: rtl/commit_queue_lane_pack.sv
// Packs each commit lane into a flat record and works out how many lanes of
// the group are kept (truncated after the first halt) and whether the mask is legal.
module commit_lane_pack
    import commit_queue_pkg::*;
#(
    parameter int COMMIT_WIDTH = CQ_DEF_COMMIT_WIDTH,
    parameter int DMEM_AW      = CQ_DEF_DMEM_AW,
    parameter int ENTRY_W      = cq_entry_w(DMEM_AW),
    parameter int K_W          = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [COMMIT_WIDTH-1:0]                in_valid,
    input  logic [COMMIT_WIDTH*32-1:0]             in_pc,
    input  logic [COMMIT_WIDTH*32-1:0]             in_instr,
    input  logic [COMMIT_WIDTH-1:0]                in_halt,
    input  logic [COMMIT_WIDTH-1:0]                in_reg_we,
    input  logic [COMMIT_WIDTH*5-1:0]              in_reg_wa,
    input  logic [COMMIT_WIDTH*32-1:0]             in_reg_wd,
    input  logic [COMMIT_WIDTH-1:0]                in_dmem_we,
    input  logic [COMMIT_WIDTH*DMEM_AW-1:0]        in_dmem_wa,
    input  logic [COMMIT_WIDTH*32-1:0]             in_dmem_wd,
    output logic [COMMIT_WIDTH-1:0][ENTRY_W-1:0]   lane_entries,
    output logic [K_W-1:0]                         lane_count,
    output logic                                   contiguous,
    output logic                                   halt_hit
);

    logic [COMMIT_WIDTH-1:0] valid_plus1;
    logic                    stop;

    for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_lane
        assign lane_entries[gi][CQ_PC_LSB +: 32]        = in_pc[gi*32 +: 32];
        assign lane_entries[gi][CQ_INSTR_LSB +: 32]     = in_instr[gi*32 +: 32];
        assign lane_entries[gi][CQ_HALT_BIT]            = in_halt[gi];
        assign lane_entries[gi][CQ_REG_WE_BIT]          = in_reg_we[gi];
        assign lane_entries[gi][CQ_REG_WA_LSB +: 5]     = in_reg_wa[gi*5 +: 5];
        assign lane_entries[gi][CQ_REG_WD_LSB +: 32]    = in_reg_wd[gi*32 +: 32];
        assign lane_entries[gi][CQ_DMEM_WE_BIT]         = in_dmem_we[gi];
        assign lane_entries[gi][CQ_DMEM_WD_LSB +: 32]   = in_dmem_wd[gi*32 +: 32];
        assign lane_entries[gi][CQ_DMEM_WA_LSB +: DMEM_AW] = in_dmem_wa[gi*DMEM_AW +: DMEM_AW];
    end

    always_comb begin
        // A mask of the form 0..01..1 has no bit in common with itself plus one.
        valid_plus1 = in_valid + COMMIT_WIDTH'(1);
        contiguous  = ((in_valid & valid_plus1) == '0);
        lane_count  = '0;
        halt_hit    = 1'b0;
        stop        = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (in_valid[i] && !stop) begin
                lane_count = lane_count + K_W'(1);
                if (in_halt[i]) begin
                    stop     = 1'b1;
                    halt_hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/commit_queue.sv
// Commit-trace FIFO: takes up to COMMIT_WIDTH retired records per cycle and
// hands them to the harness one per cycle, tracking halt and protocol errors.
module commit_queue
    import commit_queue_pkg::*;
#(
    parameter int COMMIT_WIDTH = CQ_DEF_COMMIT_WIDTH,
    parameter int DEPTH        = CQ_DEF_DEPTH,
    parameter int DMEM_AW      = CQ_DEF_DMEM_AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    commit_queue_if.slave           bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    halt_seen,
    output logic                    drained,
    output logic                    err_order,
    output logic                    err_overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = cq_entry_w(DMEM_AW);
    localparam int K_W     = $clog2(COMMIT_WIDTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next, tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next, free_slots, push_n;
    logic             halt_seen_reg, halt_seen_next;
    logic             err_order_reg, err_order_next;
    logic             err_overflow_reg, err_overflow_next;

    logic [COMMIT_WIDTH-1:0][ENTRY_W-1:0] lane_entries;
    logic [K_W-1:0]     lane_count;
    logic               contiguous, halt_hit;
    logic               ready, push_any, accept, pop;
    logic [ENTRY_W-1:0] head_entry;

    commit_lane_pack #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .DMEM_AW      (DMEM_AW),
        .ENTRY_W      (ENTRY_W),
        .K_W          (K_W)
    ) u_pack (
        .in_valid     (bus.in_valid),
        .in_pc        (bus.in_pc),
        .in_instr     (bus.in_instr),
        .in_halt      (bus.in_halt),
        .in_reg_we    (bus.in_reg_we),
        .in_reg_wa    (bus.in_reg_wa),
        .in_reg_wd    (bus.in_reg_wd),
        .in_dmem_we   (bus.in_dmem_we),
        .in_dmem_wa   (bus.in_dmem_wa),
        .in_dmem_wd   (bus.in_dmem_wd),
        .lane_entries (lane_entries),
        .lane_count   (lane_count),
        .contiguous   (contiguous),
        .halt_hit     (halt_hit)
    );

    always_comb begin
        // Ready only depends on registered state, so no input reaches it combinationally.
        free_slots = CNT_W'(DEPTH) - count_reg;
        ready      = !halt_seen_reg && (free_slots >= CNT_W'(COMMIT_WIDTH));
        push_any   = |bus.in_valid;
        accept     = ready && push_any && contiguous;
        pop        = (count_reg != '0) && bus.out_ready;
        push_n     = accept ? CNT_W'(lane_count) : '0;
        count_next = count_reg + push_n - CNT_W'(pop);
        head_next  = head_reg + PTR_W'(pop);
        tail_next  = tail_reg + PTR_W'(push_n);

        halt_seen_next    = halt_seen_reg | (accept & halt_hit);
        err_order_next    = err_order_reg | (push_any & ~contiguous);
        err_overflow_next = err_overflow_reg | (push_any & ~ready & ~halt_seen_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            halt_seen_reg    <= 1'b0;
            err_order_reg    <= 1'b0;
            err_overflow_reg <= 1'b0;
        end else begin
            head_reg         <= head_next;
            tail_reg         <= tail_next;
            count_reg        <= count_next;
            halt_seen_reg    <= halt_seen_next;
            err_order_reg    <= err_order_next;
            err_overflow_reg <= err_overflow_next;
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (i < int'(lane_count)) begin
                    mem[tail_reg + PTR_W'(i)] <= lane_entries[i];
                end
            end
        end
    end

    assign head_entry = mem[head_reg];

    assign bus.in_ready    = ready;
    assign bus.out_valid   = (count_reg != '0);
    assign bus.out_pc      = head_entry[CQ_PC_LSB +: 32];
    assign bus.out_instr   = head_entry[CQ_INSTR_LSB +: 32];
    assign bus.out_halt    = head_entry[CQ_HALT_BIT];
    assign bus.out_reg_we  = head_entry[CQ_REG_WE_BIT];
    assign bus.out_reg_wa  = head_entry[CQ_REG_WA_LSB +: 5];
    assign bus.out_reg_wd  = head_entry[CQ_REG_WD_LSB +: 32];
    assign bus.out_dmem_we = head_entry[CQ_DMEM_WE_BIT];
    assign bus.out_dmem_wa = head_entry[CQ_DMEM_WA_LSB +: DMEM_AW];
    assign bus.out_dmem_wd = head_entry[CQ_DMEM_WD_LSB +: 32];

    assign count        = count_reg;
    assign halt_seen    = halt_seen_reg;
    assign drained      = halt_seen_reg && (count_reg == '0);
    assign err_order    = err_order_reg;
    assign err_overflow = err_overflow_reg;

endmodule

// File: doc/commit_queue.md
Name: commit_queue

Overview:
- Parametrised commit-trace buffer between a multi-issue or pipelined CPU's commit stage and the simulation/difftest harness.
- Accepts up to COMMIT_WIDTH retired-instruction records per cycle, in program order.
- Stores them in a circular FIFO and presents them one per cycle to the harness through a valid/ready handshake.
- Tracks halt, backpressure and protocol errors, so the harness never sees more than one commit per cycle, whatever the CPU's retire width.

Parameters:
- COMMIT_WIDTH, 2, number of commit lanes from the CPU (1..4).
- DEPTH, 16, FIFO entries; power of two, at least 2*COMMIT_WIDTH.
- DMEM_AW, `DATA_MEM_DEPTH, width of the word-addressed data-memory write address in a record.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  COMMIT_WIDTH  per-lane commit valid; lane 0 is oldest.
- in_ready  out  1  queue can accept a full COMMIT_WIDTH group this cycle.
- in_pc  in  COMMIT_WIDTH*32  lane i at [i*32+31:i*32]; same lane slicing applies to every in_* bus below.
- in_instr  in  COMMIT_WIDTH*32  committed instruction word.
- in_halt  in  COMMIT_WIDTH  lane commits a halt.
- in_reg_we  in  COMMIT_WIDTH  register write enable.
- in_reg_wa  in  COMMIT_WIDTH*5  register write address.
- in_reg_wd  in  COMMIT_WIDTH*32  register write data.
- in_dmem_we  in  COMMIT_WIDTH  data-memory write enable.
- in_dmem_wa  in  COMMIT_WIDTH*DMEM_AW  word address.
- in_dmem_wd  in  COMMIT_WIDTH*32  data-memory write data.
- out_valid  out  1  head record valid.
- out_ready  in  1  harness consumes the head.
- out_pc, out_instr, out_halt, out_reg_we, out_reg_wa, out_reg_wd, out_dmem_we, out_dmem_wa, out_dmem_wd  out  (32,32,1,1,5,32,1,DMEM_AW,32)  head record fields.
- count  out  $clog2(DEPTH)+1  current occupancy.
- halt_seen  out  1  sticky; a halt record has been accepted.
- drained  out  1  halt_seen and queue empty.
- err_order  out  1  sticky; a non-contiguous in_valid mask was presented.
- err_overflow  out  1  sticky; a push was attempted while in_ready was low.

Behaviour:
- Reset (rst low, asynchronous):
  - head, tail and count clear to 0.
  - halt_seen, err_order and err_overflow clear to 0.
  - out_valid is 0; in_ready is 1.
  - Any contents in flight are discarded.
  - Storage array is not reset; out_* data are don't-care while out_valid is 0.
- in_ready = !halt_seen && (DEPTH - count >= COMMIT_WIDTH). This is conservative and independent of in_valid and out_ready, so there is no combinational path.
- Push:
  - Occurs when in_ready and in_valid != 0.
  - Lanes 0..k-1 are written at tail, tail+1, ... (mod DEPTH), where k = popcount(in_valid).
  - tail advances by k with wrap-around.
- Mask rule:
  - in_valid must be contiguous from bit 0 (e.g. 01, 11, 0111).
  - On a non-contiguous mask, err_order sets and the whole group is dropped.
- Halt:
  - If an accepted lane j has in_halt=1, lanes 0..j are stored and lanes above j are discarded.
  - halt_seen sets on the next edge; in_ready then stays 0 until reset.
- Overflow: in_valid != 0 while in_ready=0 sets err_overflow (unless halt_seen) and nothing is stored.
- Pop:
  - out_valid = (count != 0).
  - On out_valid && out_ready, head advances by 1 (mod DEPTH).
  - out_ready while empty has no effect.
- Simultaneous push and pop in the same cycle: count_next = count + k - 1.
- Latency:
  - A record pushed at edge t is at the head no earlier than cycle t+1.
  - Into an empty queue, lane 0 appears on out_* in the cycle after the push.
- Head fields are read combinationally from storage at head; they stay stable while out_valid && !out_ready.
- drained = halt_seen && count==0. The harness ends simulation on drained.

Decomposition:
- Shared header (configs.vh) holds:
  - record field widths and bit offsets;
  - CQ_ENTRY_W = 32+32+1+1+5+32+1+DMEM_AW+32;
  - default COMMIT_WIDTH and DEPTH.
- One sub-module, commit_lane_pack: combinational.
  - Packs/unpacks the lane slice into a CQ_ENTRY_W vector.
  - Computes the halt-truncated valid count k and the contiguity check.
- Pointer and count logic stays in commit_queue.

Test Plan:
1. Reset, then in_valid=01, pc=0x1c000000 -> next cycle out_valid=1, out_pc=0x1c000000, count=1; pop -> count=0, out_valid=0.
2. COMMIT_WIDTH=2, DEPTH=16, in_valid=11 every cycle, out_ready=0 -> after 7 pushes count=14 and in_ready=1; after 8 pushes count=16 and in_ready=0. Then in_valid=11 again -> err_overflow=1, count stays 16.
3. Steady in_valid=11 with out_ready=1 -> count grows by 1 per cycle until in_ready drops; pc order is preserved across the tail wrap at index 15->0.
4. in_valid=11, lane0 halt=1, lane1 pc=0x1c000010 -> only lane 0 stored, halt_seen=1, in_ready=0; after pop, drained=1 and 0x1c000010 never appears.
5. in_valid=10 -> err_order=1, count unchanged.
6. Assert rst low mid-burst with count=9 -> count=0, out_valid=0 immediately; release, push 01 -> normal operation, flags clear.
